ysyx_24120009_wbu: RTL and testbench



---
 rtl/ysyx_24120009_wbu_pkg.sv | 24 ++
 rtl/ysyx_24120009_wbu_if.sv | 40 ++++
 rtl/ysyx_24120009_load_ext.sv | 28 ++
 rtl/ysyx_24120009_wbu.sv | 113 +++++++++++
 tb/tb_ysyx_24120009_wbu.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_24120009_wbu_pkg.sv
// Shared encodings for the ysyx_24120009 write-back unit: write-back source
// select, FSM states and the load-size funct3 codes.
package ysyx_24120009_wbu_pkg;

  typedef enum logic [1:0] {
    WB_SEL_ALU = 2'b00,
    WB_SEL_MEM = 2'b01,
    WB_SEL_PC4 = 2'b10,
    WB_SEL_CSR = 2'b11
  } wb_sel_e;

  typedef enum logic [1:0] {
    WBU_IDLE     = 2'b00,
    WBU_WAIT_MEM = 2'b01,
    WBU_COMMIT   = 2'b10
  } wbu_state_e;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

endpackage

// File: rtl/ysyx_24120009_wbu_if.sv
// EXU->WBU instruction handshake, LSU load return, register-file write port
// and commit/difftest outputs of the write-back unit.
interface ysyx_24120009_wbu_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_WIDTH-1:0]     in_pc;
  logic [DATA_WIDTH-1:0]     in_next_pc;
  logic [DATA_WIDTH-1:0]     in_alu_result;
  logic [DATA_WIDTH-1:0]     in_csr_rdata;
  logic [REG_ADDR_WIDTH-1:0] in_rd_addr;
  logic                      in_reg_wen;
  logic [1:0]                in_wb_sel;
  logic [2:0]                in_funct3;
  logic                      mem_rvalid;
  logic [DATA_WIDTH-1:0]     mem_rdata;
  logic                      rf_wen;
  logic [REG_ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0]     rf_wdata;
  logic                      commit_valid;
  logic [DATA_WIDTH-1:0]     commit_pc;
  logic [DATA_WIDTH-1:0]     commit_next_pc;
  logic [63:0]               instret;

  modport master (
    output in_valid, in_pc, in_next_pc, in_alu_result, in_csr_rdata,
           in_rd_addr, in_reg_wen, in_wb_sel, in_funct3, mem_rvalid, mem_rdata,
    input  in_ready, rf_wen, rf_waddr, rf_wdata, commit_valid, commit_pc,
           commit_next_pc, instret
  );

  modport slave (
    input  in_valid, in_pc, in_next_pc, in_alu_result, in_csr_rdata,
           in_rd_addr, in_reg_wen, in_wb_sel, in_funct3, mem_rvalid, mem_rdata,
    output in_ready, rf_wen, rf_waddr, rf_wdata, commit_valid, commit_pc,
           commit_next_pc, instret
  );
endinterface

// File: rtl/ysyx_24120009_load_ext.sv
// Load extension: picks the addressed byte/half out of the aligned LSU word
// and sign- or zero-extends it according to funct3.
module ysyx_24120009_load_ext
  import ysyx_24120009_wbu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic [1:0]            off,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] load_data
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = mem_rdata[{off, 3'b000} +: 8];
  assign half_v = mem_rdata[{off[1], 4'b0000} +: 16];

  always_comb begin
    case (funct3)
      FUNCT3_LB:  load_data = {{(DATA_WIDTH-8){byte_v[7]}}, byte_v};
      FUNCT3_LBU: load_data = {{(DATA_WIDTH-8){1'b0}}, byte_v};
      FUNCT3_LH:  load_data = {{(DATA_WIDTH-16){half_v[15]}}, half_v};
      FUNCT3_LHU: load_data = {{(DATA_WIDTH-16){1'b0}}, half_v};
      default:    load_data = mem_rdata;  // LW and unused codes pass the word
    endcase
  end
endmodule

// File: rtl/ysyx_24120009_wbu.sv
// Write-back unit: accepts one instruction from EXU, waits for load data when
// needed, then drives a one-cycle register write together with the commit pulse.
module ysyx_24120009_wbu
  import ysyx_24120009_wbu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ysyx_24120009_wbu_if.slave       bus
);
  wbu_state_e state_q, state_d;

  logic                      in_ready;
  logic                      commit;
  logic                      accept;
  logic                      load_done;
  logic                      is_load;
  logic [DATA_WIDTH-1:0]     wb_src;
  logic [DATA_WIDTH-1:0]     load_data;

  logic [DATA_WIDTH-1:0]     pc_q;
  logic [DATA_WIDTH-1:0]     next_pc_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic                      reg_wen_q;
  logic [2:0]                funct3_q;
  logic [1:0]                off_q;
  logic [63:0]               instret_q;

  assign is_load   = (wb_sel_e'(bus.in_wb_sel) == WB_SEL_MEM);
  assign accept    = in_ready & bus.in_valid;
  assign load_done = (state_q == WBU_WAIT_MEM) & bus.mem_rvalid;

  // NOTE: sequential state is written only with non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= WBU_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every signal is defaulted before the case so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    commit   = 1'b0;
    case (state_q)
      WBU_IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_d = is_load ? WBU_WAIT_MEM : WBU_COMMIT;
      end
      WBU_WAIT_MEM: begin
        if (bus.mem_rvalid) state_d = WBU_COMMIT;
      end
      WBU_COMMIT: begin
        commit  = 1'b1;
        state_d = WBU_IDLE;
      end
      default: state_d = WBU_IDLE;
    endcase
  end

  // Write-back source for non-load instructions; MEM is resolved later.
  always_comb begin
    case (wb_sel_e'(bus.in_wb_sel))
      WB_SEL_PC4: wb_src = bus.in_pc + DATA_WIDTH'(4);
      WB_SEL_CSR: wb_src = bus.in_csr_rdata;
      default:    wb_src = bus.in_alu_result;
    endcase
  end

  ysyx_24120009_load_ext #(.DATA_WIDTH(DATA_WIDTH)) u_load_ext (
    .mem_rdata (bus.mem_rdata),
    .off       (off_q),
    .funct3    (funct3_q),
    .load_data (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= '0;
      next_pc_q <= '0;
      wdata_q   <= '0;
      rd_q      <= '0;
      reg_wen_q <= 1'b0;
      funct3_q  <= '0;
      off_q     <= '0;
      instret_q <= '0;
    end else begin
      if (accept) begin
        pc_q      <= bus.in_pc;
        next_pc_q <= bus.in_next_pc;
        rd_q      <= bus.in_rd_addr;
        reg_wen_q <= bus.in_reg_wen;
        funct3_q  <= bus.in_funct3;
        off_q     <= bus.in_alu_result[1:0];
        if (!is_load) wdata_q <= wb_src;
      end
      if (load_done) wdata_q <= load_data;
      // Counted on entry to COMMIT so the commit cycle already shows the new count.
      if ((accept && !is_load) || load_done) instret_q <= instret_q + 64'd1;
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.rf_wen         = commit & reg_wen_q & (rd_q != '0);
  assign bus.rf_waddr       = commit ? rd_q      : '0;
  assign bus.rf_wdata       = commit ? wdata_q   : '0;
  assign bus.commit_valid   = commit;
  assign bus.commit_pc      = commit ? pc_q      : '0;
  assign bus.commit_next_pc = commit ? next_pc_q : '0;
  assign bus.instret        = instret_q;
endmodule

// File: tb/tb_ysyx_24120009_wbu.sv
// Directed bench for ysyx_24120009_wbu: expected commits are queued when an
// instruction is driven and compared when the commit pulse appears.
module tb_ysyx_24120009_wbu;
  import ysyx_24120009_wbu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ysyx_24120009_wbu_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

  ysyx_24120009_wbu #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [31:0] next_pc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          commits = 0;
  logic [63:0] exp_instret = 64'd0;

  localparam logic [31:0] LOAD_WORD = 32'h8081_82F3;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference load extension written as shift-then-mask.
  function automatic logic [31:0] load_model(input logic [31:0] w, input logic [1:0] off,
                                             input logic [2:0] f3);
    logic [31:0] b;
    logic [31:0] h;
    b = w >> (8 * off);
    h = w >> (off[1] ? 16 : 0);
    case (f3)
      3'b000:  return (b & 32'hFF) | (b[7] ? 32'hFFFF_FF00 : 32'h0);
      3'b100:  return b & 32'hFF;
      3'b001:  return (h & 32'hFFFF) | (h[15] ? 32'hFFFF_0000 : 32'h0);
      3'b101:  return h & 32'hFFFF;
      default: return w;
    endcase
  endfunction

  // Commit monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_instret = 64'd0;
    end else begin
      check("rf_wen_outside_commit", 64'(bus.rf_wen & ~bus.commit_valid), 64'd0);
      if (bus.commit_valid) begin
        commits++;
        if (sb.size() == 0) begin
          check("spurious_commit", 64'(bus.commit_valid), 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          exp_instret = exp_instret + 64'd1;
          check("rf_wen", 64'(bus.rf_wen), 64'(e.wen));
          check("rf_waddr", 64'(bus.rf_waddr), 64'(e.rd));
          check("rf_wdata", 64'(bus.rf_wdata), 64'(e.wdata));
          check("commit_pc", 64'(bus.commit_pc), 64'(e.pc));
          check("commit_next_pc", 64'(bus.commit_next_pc), 64'(e.next_pc));
          check("instret", bus.instret, exp_instret);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_ready();
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_timeout", 64'(bus.in_ready), 64'd1);
  endtask

  task automatic send(input logic [31:0] pc, input logic [31:0] next_pc, input logic [31:0] alu,
                      input logic [31:0] csr, input logic [4:0] rd, input logic wen,
                      input logic [1:0] sel, input logic [2:0] f3, input logic [31:0] exp_wdata,
                      input bit expect_commit);
    wait_ready();
    bus.in_pc         = pc;
    bus.in_next_pc    = next_pc;
    bus.in_alu_result = alu;
    bus.in_csr_rdata  = csr;
    bus.in_rd_addr    = rd;
    bus.in_reg_wen    = wen;
    bus.in_wb_sel     = sel;
    bus.in_funct3     = f3;
    bus.in_valid      = 1'b1;
    if (expect_commit) sb.push_back('{rd, wen && (rd != 5'd0), exp_wdata, pc, next_pc});
    @(posedge clk); #1;
    bus.in_valid      = 1'b0;
    bus.in_alu_result = $urandom;
    bus.in_wb_sel     = 2'($urandom);
  endtask

  task automatic mem_respond(input int delay, input logic [31:0] word);
    for (int i = 0; i < delay; i++) begin
      check("wait_mem_in_ready", 64'(bus.in_ready), 64'd0);
      check("wait_mem_no_commit", 64'(bus.commit_valid), 64'd0);
      bus.mem_rdata = $urandom;
      @(posedge clk); #1;
    end
    check("wait_mem_in_ready", 64'(bus.in_ready), 64'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = word;
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk); #1;
    check("drain_pending", 64'(sb.size()), 64'd0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [2:0] f3;
    logic [1:0] off;
    int         delay;
  } load_t;

  initial begin
    load_t loads[8];
    int    c0;
    int    accepts;
    int    last;
    int    cyc;

    bus.in_valid = 1'b0;  bus.in_pc = '0;       bus.in_next_pc = '0;
    bus.in_alu_result = '0; bus.in_csr_rdata = '0; bus.in_rd_addr = '0;
    bus.in_reg_wen = 1'b0; bus.in_wb_sel = '0;   bus.in_funct3 = '0;
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;

    // Reset values, observed while reset is held.
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_rf_wen", 64'(bus.rf_wen), 64'd0);
    check("rst_rf_waddr", 64'(bus.rf_waddr), 64'd0);
    check("rst_rf_wdata", 64'(bus.rf_wdata), 64'd0);
    check("rst_commit_valid", 64'(bus.commit_valid), 64'd0);
    check("rst_commit_pc", 64'(bus.commit_pc), 64'd0);
    check("rst_commit_next_pc", 64'(bus.commit_next_pc), 64'd0);
    check("rst_instret", bus.instret, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADDI-style ALU write.
    send(32'h8000_0000, 32'h8000_0004, 32'h0000_0123, 32'h0, 5'd5, 1'b1, WB_SEL_ALU, 3'b000,
         32'h0000_0123, 1'b1);
    drain();
    check("instret_after_addi", bus.instret, 64'd1);

    // JAL link values, including PC+4 wrap, and a CSR read.
    send(32'h8000_0010, 32'h8000_0200, 32'h8000_0200, 32'h0, 5'd1, 1'b1, WB_SEL_PC4, 3'b000,
         32'h8000_0014, 1'b1);
    drain();
    send(32'hFFFF_FFFC, 32'h8000_0000, 32'h8000_0000, 32'h0, 5'd1, 1'b1, WB_SEL_PC4, 3'b000,
         32'h0000_0000, 1'b1);
    drain();
    send(32'h8000_0020, 32'h8000_0024, 32'h0000_0300, 32'hDEAD_BEEF, 5'd7, 1'b1, WB_SEL_CSR,
         3'b010, 32'hDEAD_BEEF, 1'b1);
    drain();

    // Load sweep; the LW entry also stalls mem_rvalid for 5 cycles.
    loads[0] = '{3'b000, 2'd0, 0};
    loads[1] = '{3'b100, 2'd3, 1};
    loads[2] = '{3'b001, 2'd2, 2};
    loads[3] = '{3'b101, 2'd0, 0};
    loads[4] = '{3'b010, 2'd0, 5};
    loads[5] = '{3'b000, 2'd1, 0};
    loads[6] = '{3'b101, 2'd2, 1};
    loads[7] = '{3'b011, 2'd0, 0};
    for (int i = 0; i < 8; i++) begin
      c0 = commits;
      send(32'h8000_0100 + 32'(4 * i), 32'h8000_0104 + 32'(4 * i),
           32'h8000_1000 | 32'(loads[i].off), 32'h0, 5'(8 + i), 1'b1, WB_SEL_MEM, loads[i].f3,
           load_model(LOAD_WORD, loads[i].off, loads[i].f3), 1'b1);
      mem_respond(loads[i].delay, LOAD_WORD);
      drain();
      check("load_commit_once", 64'(commits - c0), 64'd1);
    end

    // Write to x0: commit without a register write.
    send(32'h8000_0200, 32'h8000_0204, 32'h0000_0055, 32'h0, 5'd0, 1'b1, WB_SEL_ALU, 3'b000,
         32'h0000_0055, 1'b1);
    drain();

    // mem_rvalid while idle is ignored.
    c0 = commits;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1234_5678;
    repeat (2) begin
      @(posedge clk); #1;
      check("idle_rvalid_in_ready", 64'(bus.in_ready), 64'd1);
    end
    bus.mem_rvalid = 1'b0;
    @(posedge clk); #1;
    check("idle_rvalid_no_commit", 64'(commits - c0), 64'd0);

    // Back-to-back: in_valid held high across four instructions.
    apply_reset();
    c0 = commits;
    accepts = 0;
    last = 0;
    cyc = 0;
    bus.in_wb_sel  = WB_SEL_ALU;
    bus.in_reg_wen = 1'b1;
    bus.in_valid   = 1'b1;
    while (accepts < 4 && cyc < 40) begin
      if (bus.in_ready) begin
        bus.in_pc         = 32'h8000_0300 + 32'(4 * accepts);
        bus.in_next_pc    = 32'h8000_0304 + 32'(4 * accepts);
        bus.in_alu_result = 32'h0000_1000 + 32'(accepts);
        bus.in_rd_addr    = 5'(10 + accepts);
        sb.push_back('{5'(10 + accepts), 1'b1, 32'h0000_1000 + 32'(accepts),
                       32'h8000_0300 + 32'(4 * accepts), 32'h8000_0304 + 32'(4 * accepts)});
        if (accepts > 0) check("b2b_spacing", 64'(cyc - last), 64'd2);
        last = cyc;
        accepts++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    check("b2b_accepts", 64'(accepts), 64'd4);
    drain();
    check("b2b_commits", 64'(commits - c0), 64'd4);
    check("b2b_instret", bus.instret, 64'd4);

    // Reset while waiting for load data aborts the instruction.
    c0 = commits;
    send(32'h8000_0400, 32'h8000_0404, 32'h8000_2002, 32'h0, 5'd9, 1'b1, WB_SEL_MEM, 3'b001,
         32'h0, 1'b0);
    @(posedge clk); #1;
    check("abort_wait_in_ready", 64'(bus.in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("abort_rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("abort_rst_rf_wen", 64'(bus.rf_wen), 64'd0);
    check("abort_rst_commit", 64'(bus.commit_valid), 64'd0);
    check("abort_rst_instret", bus.instret, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = LOAD_WORD;
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort_no_commit", 64'(commits - c0), 64'd0);
    check("abort_in_ready", 64'(bus.in_ready), 64'd1);
    check("abort_instret", bus.instret, 64'd0);

    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
